// File: rtl/sim_link_responder_pkg.sv
// Shared constants for the simulated link responder: command/status bit
// positions, the command header and the Rx/Tx state encodings.
package sim_link_responder_pkg;

    localparam logic [1:0] CMD_HEADER = 2'b10;

    localparam int CMD_FWD     = 0;
    localparam int CMD_BWD     = 1;
    localparam int CMD_LEFT    = 2;
    localparam int CMD_RIGHT   = 3;
    localparam int CMD_PLACE   = 4;
    localparam int CMD_DESTROY = 5;

    localparam int STAT_FRONT = 0;
    localparam int STAT_LEFT  = 1;
    localparam int STAT_RIGHT = 2;
    localparam int STAT_BACK  = 3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // Contradictory movement or turn requests cancel each other out.
    function automatic logic [5:0] filter_cmd(input logic [5:0] raw);
        logic [5:0] c;
        c = raw;
        if (c[CMD_FWD] && c[CMD_BWD]) begin
            c[CMD_FWD] = 1'b0;
            c[CMD_BWD] = 1'b0;
        end
        if (c[CMD_LEFT] && c[CMD_RIGHT]) begin
            c[CMD_LEFT]  = 1'b0;
            c[CMD_RIGHT] = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/sim_uart_tx.sv
// 8N1 UART transmitter: accepts a byte when idle and valid, holds each bit BIT_CYC cycles.
module sim_uart_tx
    import sim_link_responder_pkg::*;
#(
    parameter int BIT_CYC = 10416
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       busy,
    output logic       txd
);

    localparam int BW = $clog2(BIT_CYC + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYC - 1);

    logic [1:0]    state_reg;
    logic [BW-1:0] cnt_reg;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg;
    logic          txd_reg;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_reg <= TX_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
        end else begin
            case (state_reg)
                TX_IDLE: begin
                    if (valid) begin
                        state_reg <= TX_START;
                        shift_reg <= data;
                        txd_reg   <= 1'b0;
                        cnt_reg   <= '0;
                    end
                end
                TX_START: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= TX_DATA;
                        txd_reg   <= shift_reg[0];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg <= '0;
                        bit_reg <= bit_reg + 1'b1;
                        if (bit_reg == 3'd7) begin
                            state_reg <= TX_STOP;
                            txd_reg   <= 1'b1;
                        end else begin
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            txd_reg   <= shift_reg[1];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= TX_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= TX_IDLE;
            endcase
        end
    end

    assign busy = (state_reg != TX_IDLE);
    assign txd  = txd_reg;

endmodule

// File: rtl/sim_link_responder.sv
// Simulated robot link: decodes UART command frames into levels with a link
// watchdog, and periodically reports detector levels as UART status frames.
module sim_link_responder
    import sim_link_responder_pkg::*;
#(
    parameter int BIT_CYC       = 10416,
    parameter int STATUS_PERIOD = 2_000_000,
    parameter int LINK_TIMEOUT  = 10_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic rxd,
    output logic txd,
    input  logic front_det,
    input  logic left_det,
    input  logic right_det,
    input  logic back_det,
    output logic move_forward,
    output logic move_backward,
    output logic turn_left,
    output logic turn_right,
    output logic place_barrier,
    output logic destroy_barrier,
    output logic cmd_strobe,
    output logic frame_err,
    output logic link_alive
);

    localparam int BW = $clog2(BIT_CYC + 1);
    localparam int PW = $clog2(STATUS_PERIOD + 1);
    localparam int WW = $clog2(LINK_TIMEOUT + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CYC - 1);
    localparam logic [BW-1:0] HALF_LAST = (BIT_CYC / 2 > 0) ? BW'(BIT_CYC / 2 - 1) : '0;
    localparam logic [PW-1:0] PER_LAST  = PW'(STATUS_PERIOD - 1);
    localparam logic [WW-1:0] WD_MAX    = WW'(LINK_TIMEOUT);

    // ---------------- Rx ----------------
    logic          sync1_reg, sync2_reg, prev_reg;
    logic [1:0]    rx_state_reg;
    logic [BW-1:0] rx_cnt_reg;
    logic [2:0]    rx_bit_reg;
    logic [7:0]    rx_shift_reg;
    logic          rx_fall, stop_sample, frame_good, frame_bad;

    assign rx_fall     = prev_reg & ~sync2_reg;
    assign stop_sample = (rx_state_reg == RX_STOP) && (rx_cnt_reg == BIT_LAST);
    assign frame_good  = stop_sample && sync2_reg && (rx_shift_reg[7:6] == CMD_HEADER);
    assign frame_bad   = stop_sample && !(sync2_reg && (rx_shift_reg[7:6] == CMD_HEADER));

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            prev_reg     <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_reg <= RX_START;
                        rx_cnt_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == HALF_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= '0;
                        // A line that is high again mid start bit was a glitch.
                        rx_state_reg <= sync2_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {sync2_reg, rx_shift_reg[7:1]};
                        rx_bit_reg   <= rx_bit_reg + 1'b1;
                        if (rx_bit_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_IDLE;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // ---------------- Command latch and watchdog ----------------
    logic [5:0]    cmd_reg;
    logic [WW-1:0] wd_reg;
    logic          alive_reg, strobe_reg, err_reg;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cmd_reg    <= '0;
            wd_reg     <= '0;
            alive_reg  <= 1'b0;
            strobe_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            strobe_reg <= frame_good;
            err_reg    <= frame_bad;
            if (frame_good) begin
                cmd_reg   <= filter_cmd(rx_shift_reg[5:0]);
                alive_reg <= 1'b1;
                wd_reg    <= '0;
            end else if (wd_reg != WD_MAX) begin
                wd_reg <= wd_reg + 1'b1;
                if (wd_reg == WD_MAX - 1'b1) begin
                    alive_reg <= 1'b0;
                    cmd_reg   <= '0;
                end
            end
        end
    end

    assign move_forward    = cmd_reg[CMD_FWD];
    assign move_backward   = cmd_reg[CMD_BWD];
    assign turn_left       = cmd_reg[CMD_LEFT];
    assign turn_right      = cmd_reg[CMD_RIGHT];
    assign place_barrier   = cmd_reg[CMD_PLACE];
    assign destroy_barrier = cmd_reg[CMD_DESTROY];
    assign cmd_strobe      = strobe_reg;
    assign frame_err       = err_reg;
    assign link_alive      = alive_reg;

    // ---------------- Tx ----------------
    logic [PW-1:0] per_reg;
    logic          pending_reg, per_wrap, tx_valid, tx_busy;
    logic [3:0]    det;
    logic [7:0]    status_byte;

    assign det[STAT_FRONT] = front_det;
    assign det[STAT_LEFT]  = left_det;
    assign det[STAT_RIGHT] = right_det;
    assign det[STAT_BACK]  = back_det;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_status
            if (gi < 4) begin : g_det
                assign status_byte[gi] = det[gi];
            end else begin : g_zero
                assign status_byte[gi] = 1'b0;
            end
        end
    endgenerate

    assign per_wrap = (per_reg == PER_LAST);
    assign tx_valid = (per_wrap || pending_reg) && !tx_busy;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            per_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            per_reg <= per_wrap ? '0 : per_reg + 1'b1;
            if (tx_valid) begin
                pending_reg <= 1'b0;
            end else if (per_wrap && tx_busy) begin
                pending_reg <= 1'b1;
            end
        end
    end

    sim_uart_tx #(
        .BIT_CYC(BIT_CYC)
    ) u_tx (
        .sys_clk(sys_clk),
        .rst    (rst),
        .data   (status_byte),
        .valid  (tx_valid),
        .busy   (tx_busy),
        .txd    (txd)
    );

endmodule

// File: doc/sim_link_responder.md
SIM_LINK_RESPONDER -- requirements
Module: sim_link_responder

Interface
REQ-001 BIT_CYC, 10416, sys_clk cycles per UART bit (100 MHz / 9600 baud).
REQ-002 STATUS_PERIOD, 2_000_000, cycles between status-frame starts (20 ms).
REQ-003 LINK_TIMEOUT, 10_000_000, cycles without a valid command frame before link is declared lost (100 ms).
REQ-004 sys_clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 rxd  in  1  UART line carrying command frames from the controller; idle high.
REQ-007 txd  out  1  UART line carrying status frames to the controller; idle high.
REQ-008 front_det, left_det, right_det, back_det  in  1 each  simulated detector levels.
REQ-009 move_forward, move_backward, turn_left, turn_right, place_barrier, destroy_barrier  out  1 each  decoded command levels.
REQ-010 cmd_strobe  out  1  one-cycle pulse when a valid command is latched.
REQ-011 frame_err  out  1  one-cycle pulse on a bad stop bit or bad header.
REQ-012 link_alive  out  1  high while valid frames arrive within LINK_TIMEOUT.

Function
REQ-013 Framing on both lines: 8N1, LSB first, one start bit (0), one stop bit (1).
REQ-014 Rx: a 2-flop synchroniser on rxd; start detected on a 1->0 edge while idle; sampling at BIT_CYC/2 after the edge, then every BIT_CYC.
REQ-015 Rx FSM states: IDLE, START, DATA(8 bits), STOP; a start sample of 1 returns to IDLE (glitch reject) with no error.
REQ-016 Command byte layout: [7:6] header, [5] destroy, [4] place, [3] right, [2] left, [1] backward, [0] forward.
REQ-017 Valid frame: stop sample = 1 and header = 2'b10; the six command outputs are updated from the byte, and cmd_strobe pulses, one cycle after the stop-bit sample.
REQ-018 Invalid frame (stop = 0 or header != 2'b10): outputs unchanged; frame_err pulses one cycle after the stop sample.
REQ-019 move_forward and move_backward both set in one frame: both outputs forced to 0; turn_left and turn_right both set: both forced to 0; the rest of the byte still applies.
REQ-020 Watchdog: counter cleared on each valid frame; on reaching LINK_TIMEOUT, link_alive goes 0 and all six command outputs go 0 in the same cycle; the next valid frame sets link_alive = 1.
REQ-021 Tx: free-running period counter; at each wrap, detectors are sampled into a byte {4'b0000, back, right, left, front} (bit0 = front).
REQ-022 Tx FSM states: IDLE, START, DATA, STOP, each bit held BIT_CYC cycles; one frame = 10*BIT_CYC cycles.
REQ-023 A period wrap during an ongoing transmission sets a pending flag (depth 1); the pending frame starts the cycle after STOP completes, using detectors sampled at that moment.
REQ-024 Rx and Tx operate independently; simultaneous receive and transmit carry no ordering constraint.
REQ-025 Counters saturate or wrap only as stated; bit counters are 3 bits and wrap 7->0 at DATA exit.

Reset
REQ-026 When rst = 0: txd = 1, all command outputs = 0, cmd_strobe = frame_err = 0, link_alive = 0, both FSMs IDLE, all counters 0, pending flag clear.
REQ-027 Reset asserted mid-frame aborts the frame; after release, Rx waits for a fresh 1->0 edge and Tx waits for the next period wrap.

Structure
REQ-028 The shared package holds CMD_HEADER = 2'b10, the command and status bit-index constants, and the Rx/Tx state encodings.
REQ-029 Rx and Tx are separate always-block groups; one sub-module, sim_uart_tx (byte-in/valid, busy, txd), is instantiated, and Rx stays inline.

Verification (BIT_CYC = 16, STATUS_PERIOD = 400, LINK_TIMEOUT = 2000)
REQ-030 Send 0x81 -> move_forward = 1, all other commands 0, one cmd_strobe, link_alive = 1.
REQ-031 Send 0x41 (bad header), then a frame with stop bit = 0 -> two frame_err pulses; outputs keep their previous values.
REQ-032 Send 0x8F (forward+backward+left+right) -> all four movement/turn outputs = 0; strobe still pulses.
REQ-033 Hold left_det = 1, front_det = 1 -> txd carries 0x03 each period; the decoded bit time is 16 cycles.
REQ-034 After 0x84, send no frames for 2000 cycles -> turn_left = 0, link_alive = 0; a further 0x84 restores both.
REQ-035 Assert rst mid-Rx-byte and mid-Tx-byte -> txd = 1 immediately and no strobe/err; a subsequent 0x82 decodes correctly.
